// File: rtl/color_math_pipe.sv
// Three-stage colour-math pipeline: main/sub add or subtract with clamp and halve,
// then master brightness, behind a valid/ready stream with a global stall.
`timescale 1ns/1ps
module color_math_pipe #(
    parameter int CW  = 5,
    parameter int NCH = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*CW-1:0] in_main,
    input  logic [NCH*CW-1:0] in_sub,
    input  logic              in_do_math,
    input  logic              in_subtract,
    input  logic              in_half,
    input  logic              in_force_black,
    input  logic [3:0]        in_bright,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*CW-1:0] out_color
);

    localparam int RW = CW + 2;
    localparam int PW = CW + 5;

    logic stall;
    logic advance;

    logic                      s1_valid_q, s1_valid_d;
    logic [NCH-1:0][RW-1:0]    s1_r_q, s1_r_d;
    logic [NCH-1:0][CW-1:0]    s1_m_q, s1_m_d;
    logic                      s1_do_math_q, s1_do_math_d;
    logic                      s1_subtract_q, s1_subtract_d;
    logic                      s1_half_q, s1_half_d;
    logic [3:0]                s1_bright_q, s1_bright_d;

    logic                      s2_valid_q, s2_valid_d;
    logic [NCH-1:0][CW-1:0]    s2_c_q, s2_c_d;
    logic [3:0]                s2_bright_q, s2_bright_d;

    logic                      s3_valid_q, s3_valid_d;
    logic [NCH*CW-1:0]         s3_color_q, s3_color_d;

    assign stall     = s3_valid_q & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = advance;
    assign out_valid = s3_valid_q;
    assign out_color = s3_color_q;

    // Raw per-channel sum or signed difference; two guard bits hold carry and borrow.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_r_d        = s1_r_q;
        s1_m_d        = s1_m_q;
        s1_do_math_d  = s1_do_math_q;
        s1_subtract_d = s1_subtract_q;
        s1_half_d     = s1_half_q;
        s1_bright_d   = s1_bright_q;
        if (advance) begin
            s1_valid_d    = in_valid;
            s1_do_math_d  = in_do_math;
            s1_subtract_d = in_subtract;
            s1_half_d     = in_half;
            s1_bright_d   = in_bright;
            for (int k = 0; k < NCH; k++) begin
                s1_m_d[k] = in_force_black ? '0 : in_main[k*CW +: CW];
                s1_r_d[k] = in_subtract
                          ? ({2'b00, s1_m_d[k]} - {2'b00, in_sub[k*CW +: CW]})
                          : ({2'b00, s1_m_d[k]} + {2'b00, in_sub[k*CW +: CW]});
            end
        end
    end

    // Negative results only come from subtract, overflow only from add.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_c_d      = s2_c_q;
        s2_bright_d = s2_bright_q;
        if (advance) begin
            s2_valid_d  = s1_valid_q;
            s2_bright_d = s1_bright_q;
            for (int k = 0; k < NCH; k++) begin
                if (!s1_do_math_q)
                    s2_c_d[k] = s1_m_q[k];
                else if (s1_subtract_q && s1_r_q[k][CW+1])
                    s2_c_d[k] = '0;
                else if (s1_half_q)
                    s2_c_d[k] = s1_r_q[k][CW:1];
                else if (!s1_subtract_q && s1_r_q[k][CW])
                    s2_c_d[k] = '1;
                else
                    s2_c_d[k] = s1_r_q[k][CW-1:0];
            end
        end
    end

    // Brightness scales by (bright+1)/16; the colour only changes when a real pixel lands.
    always_comb begin
        s3_valid_d = s3_valid_q;
        s3_color_d = s3_color_q;
        if (advance) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                for (int k = 0; k < NCH; k++) begin
                    if (s2_bright_q == 4'd0)
                        s3_color_d[k*CW +: CW] = '0;
                    else
                        s3_color_d[k*CW +: CW] =
                            CW'((PW'(s2_c_q[k]) * PW'({1'b0, s2_bright_q} + 5'd1)) >> 4);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_r_q        <= '0;
            s1_m_q        <= '0;
            s1_do_math_q  <= 1'b0;
            s1_subtract_q <= 1'b0;
            s1_half_q     <= 1'b0;
            s1_bright_q   <= '0;
            s2_valid_q    <= 1'b0;
            s2_c_q        <= '0;
            s2_bright_q   <= '0;
            s3_valid_q    <= 1'b0;
            s3_color_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_r_q        <= s1_r_d;
            s1_m_q        <= s1_m_d;
            s1_do_math_q  <= s1_do_math_d;
            s1_subtract_q <= s1_subtract_d;
            s1_half_q     <= s1_half_d;
            s1_bright_q   <= s1_bright_d;
            s2_valid_q    <= s2_valid_d;
            s2_c_q        <= s2_c_d;
            s2_bright_q   <= s2_bright_d;
            s3_valid_q    <= s3_valid_d;
            s3_color_q    <= s3_color_d;
        end
    end

endmodule

// File: tb/tb_color_math_pipe.sv
// Directed bench for color_math_pipe: a default 5-bit/3-channel instance and a
// wide 8-bit/4-channel instance, checked against hand-computed colours.
`timescale 1ns/1ps
module tb_color_math_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid, in_ready;
    logic [14:0] in_main, in_sub;
    logic        in_do_math, in_subtract, in_half, in_force_black;
    logic [3:0]  in_bright;
    logic        out_valid, out_ready;
    logic [14:0] out_color;

    logic        w_in_valid, w_in_ready;
    logic [31:0] w_in_main, w_in_sub;
    logic        w_in_do_math, w_in_subtract, w_in_half, w_in_force_black;
    logic [3:0]  w_in_bright;
    logic        w_out_valid, w_out_ready;
    logic [31:0] w_out_color;

    int checks = 0;
    int errors = 0;

    color_math_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_main(in_main), .in_sub(in_sub),
        .in_do_math(in_do_math), .in_subtract(in_subtract),
        .in_half(in_half), .in_force_black(in_force_black),
        .in_bright(in_bright),
        .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color)
    );

    color_math_pipe #(.CW(8), .NCH(4)) dut_wide (
        .clk(clk), .reset_n(reset_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_main(w_in_main), .in_sub(w_in_sub),
        .in_do_math(w_in_do_math), .in_subtract(w_in_subtract),
        .in_half(w_in_half), .in_force_black(w_in_force_black),
        .in_bright(w_in_bright),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_color(w_out_color)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [14:0] rgb(input int r, input int g, input int b);
        return {b[4:0], g[4:0], r[4:0]};
    endfunction

    task automatic applyStimulus(input logic [14:0] main, input logic [14:0] sub,
                                 input logic dm, input logic sb, input logic hf,
                                 input logic fbk, input logic [3:0] br);
        in_main        = main;
        in_sub         = sub;
        in_do_math     = dm;
        in_subtract    = sb;
        in_half        = hf;
        in_force_black = fbk;
        in_bright      = br;
        in_valid       = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic expectPixel(input string tag, input logic [14:0] expected,
                               output int lat);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            lat = n;
            if (out_valid) break;
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_color"}, out_color, expected);
        @(posedge clk);
        #1;
    endtask

    task automatic runVector(input string tag, input logic [14:0] main,
                             input logic [14:0] sub, input logic dm, input logic sb,
                             input logic hf, input logic fbk, input logic [3:0] br,
                             input logic [14:0] expected);
        int lat;
        applyStimulus(main, sub, dm, sb, hf, fbk, br);
        expectPixel(tag, expected, lat);
    endtask

    task automatic runWide(input string tag, input logic [31:0] main,
                           input logic [31:0] sub, input logic sb, input logic hf,
                           input logic [3:0] br, input logic [31:0] expected);
        w_in_main     = main;
        w_in_sub      = sub;
        w_in_do_math  = 1'b1;
        w_in_subtract = sb;
        w_in_half     = hf;
        w_in_bright   = br;
        w_in_valid    = 1'b1;
        @(posedge clk);
        #1 w_in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (w_out_valid) break;
        end
        checkOutput({tag, "_valid"}, w_out_valid, 1);
        checkOutput({tag, "_color"}, w_out_color, expected);
        @(posedge clk);
        #1;
    endtask

    logic [14:0] px [10];

    initial begin
        int lat;
        int send_idx;
        int recv_idx;
        int seen;
        logic accept;
        logic xfer;

        reset_n = 1'b0;
        in_valid = 1'b0; in_main = '0; in_sub = '0; in_do_math = 1'b0;
        in_subtract = 1'b0; in_half = 1'b0; in_force_black = 1'b0; in_bright = 4'd15;
        out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_main = '0; w_in_sub = '0; w_in_do_math = 1'b0;
        w_in_subtract = 1'b0; w_in_half = 1'b0; w_in_force_black = 1'b0;
        w_in_bright = 4'd15; w_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) px[k] = 15'(k * 2311 + 97);

        $display("[TB] reset and latency");
        #2;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_color", out_color, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_wide_valid", w_out_valid, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_out_valid", out_valid, 0);
        checkOutput("post_rst_out_color", out_color, 0);
        checkOutput("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        applyStimulus(15'h7FFF, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
        expectPixel("latency", 15'h7FFF, lat);
        checkOutput("latency_cycles", lat, 3);
        @(negedge clk);
        checkOutput("latency_pulse_end", out_valid, 0);
        @(posedge clk);
        #1;

        $display("[TB] directed math vectors");
        runVector("add_sat",  rgb(20,10,31), rgb(20,5,31), 1, 0, 0, 0, 4'd15, rgb(31,15,31));
        runVector("add_half", rgb(20,10,31), rgb(20,5,31), 1, 0, 1, 0, 4'd15, rgb(20,7,31));
        runVector("add_half_b7", rgb(20,10,31), rgb(20,5,31), 1, 0, 1, 0, 4'd7, rgb(10,3,15));
        runVector("sub_floor", rgb(3,20,31), rgb(10,4,1), 1, 1, 0, 0, 4'd15, rgb(0,16,30));
        runVector("sub_half",  rgb(3,20,31), rgb(10,4,1), 1, 1, 1, 0, 4'd15, rgb(0,8,15));
        runVector("force_black_add", rgb(31,31,31), rgb(5,6,7), 1, 0, 0, 1, 4'd15, rgb(5,6,7));
        runVector("force_black_nomath", rgb(31,31,31), rgb(5,6,7), 0, 0, 0, 1, 4'd15, 15'h0000);
        runVector("bright7", rgb(31,16,1), rgb(9,9,9), 0, 0, 0, 0, 4'd7, rgb(15,8,0));
        runVector("bright0", rgb(31,16,1), rgb(9,9,9), 0, 0, 0, 0, 4'd0, 15'h0000);

        $display("[TB] backpressure stream");
        in_do_math = 1'b0; in_force_black = 1'b0; in_bright = 4'd15; in_sub = '0;
        send_idx = 0;
        recv_idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 10);
            in_valid  = (send_idx < 10);
            if (send_idx < 10) in_main = px[send_idx];
            @(negedge clk);
            checkOutput("bp_in_ready", in_ready, !(cyc >= 6 && cyc <= 10));
            checkOutput("bp_out_valid", out_valid, (cyc >= 3 && cyc <= 17));
            if (out_valid) begin
                if (recv_idx < 10) checkOutput("bp_color", out_color, px[recv_idx]);
                else checkOutput("bp_extra_output", out_valid, 0);
            end
            accept = in_valid && in_ready;
            xfer   = out_valid && out_ready;
            @(posedge clk);
            #1;
            if (accept) send_idx++;
            if (xfer) recv_idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("bp_sent", send_idx, 10);
        checkOutput("bp_received", recv_idx, 10);

        $display("[TB] reset with pixels in flight");
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_main = px[k];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("inflight_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid_drop", out_valid, 0);
        checkOutput("midrst_color", out_color, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1 reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("midrst_no_ghost", seen, 0);
        @(posedge clk);
        #1;
        runVector("midrst_first_out", px[5], 15'h0000, 0, 0, 0, 0, 4'd15, px[5]);

        $display("[TB] wide instance");
        runWide("wide_sat", {4{8'd200}}, {4{8'd100}}, 0, 0, 4'd15, 32'hFFFF_FFFF);
        runWide("wide_half", {4{8'd200}}, {4{8'd100}}, 0, 1, 4'd15, 32'h9696_9696);
        runWide("wide_bright3", {4{8'd200}}, {4{8'd100}}, 0, 0, 4'd3, 32'h3F3F_3F3F);
        runWide("wide_no_carry", {8'd1, 8'd128, 8'd0, 8'd255}, {8'd0, 8'd127, 8'd0, 8'd1},
                0, 0, 4'd15, 32'h01FF_00FF);
        runWide("wide_no_borrow", {8'd5, 8'd0, 8'd9, 8'd0}, {8'd1, 8'd1, 8'd4, 8'd3},
                1, 0, 4'd15, 32'h0400_0500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
